// File: rtl/fpadd_pkg.sv
// Shared definitions for the FP adder arbiter: data width, FSM state
// encoding and the requester-ID width helper.
package fpadd_pkg;

    localparam int FP_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } fpadd_state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int idWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts one above the last
// granted index and wraps, so the most recent winner has lowest priority.
module rr_arbiter
    import fpadd_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]          req,
    input  logic [idWidth(NUM_REQ)-1:0] last_gnt,
    output logic [NUM_REQ-1:0]          gnt_onehot,
    output logic [idWidth(NUM_REQ)-1:0] gnt_idx,
    output logic                        any
);

    localparam int IdW = idWidth(NUM_REQ);

    // Walk the requesters in rotated order and take the first one asserted.
    always_comb begin
        logic [IdW-1:0] idx;
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        idx        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IdW'((int'(last_gnt) + 1 + i) % NUM_REQ);
            if (!any && req[idx]) begin
                gnt_onehot[idx] = 1'b1;
                gnt_idx         = idx;
                any             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpadd_arbiter.sv
// Shares one combinational FP adder datapath between NUM_REQ requesters.
// A round-robin winner's operands are latched and held on fp_a/fp_b for
// LATENCY cycles (multicycle path), then fp_result is captured and returned
// with the requester ID over a valid/ready response channel.
module fpadd_arbiter
    import fpadd_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int LATENCY = 5
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0][FP_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ-1:0][FP_WIDTH-1:0]   req_b,
    output logic [FP_WIDTH-1:0]                fp_a,
    output logic [FP_WIDTH-1:0]                fp_b,
    input  logic [FP_WIDTH-1:0]                fp_result,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [idWidth(NUM_REQ)-1:0]        rsp_id,
    output logic [FP_WIDTH-1:0]                rsp_result,
    output logic                               busy
);

    localparam int IdW  = idWidth(NUM_REQ);
    localparam int CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    fpadd_state_t          state;
    logic [1:0]            rstSync;
    logic                  rstSyncN;
    logic                  armed;
    logic [IdW-1:0]        lastGnt;
    logic [IdW-1:0]        gntId;
    logic [CntW-1:0]       cnt;
    logic [FP_WIDTH-1:0]   opA;
    logic [FP_WIDTH-1:0]   opB;
    logic [FP_WIDTH-1:0]   res;
    logic [NUM_REQ-1:0]    gntOnehot;
    logic [IdW-1:0]        gntIdx;
    logic                  anyReq;
    logic                  accepting;

    // Reset synchronizer: asserts asynchronously, releases on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rstSync <= '0;
        else        rstSync <= {rstSync[0], 1'b1};
    end

    assign rstSyncN = rstSync[1];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) uPicker (
        .req        (req_valid),
        .last_gnt   (lastGnt),
        .gnt_onehot (gntOnehot),
        .gnt_idx    (gntIdx),
        .any        (anyReq)
    );

    // armed keeps req_ready low while reset is held and until it has released.
    assign accepting = (state == IDLE) && armed;
    assign req_ready = accepting ? gntOnehot : '0;

    assign fp_a       = opA;
    assign fp_b       = opB;
    assign rsp_valid  = (state == RESP);
    assign rsp_id     = gntId;
    assign rsp_result = res;
    assign busy       = (state != IDLE);

    // Control FSM: accept a winner, hold operands LATENCY cycles, return result.
    always_ff @(posedge clk or negedge rstSyncN) begin
        if (!rstSyncN) begin
            state   <= IDLE;
            armed   <= 1'b0;
            lastGnt <= IdW'(NUM_REQ - 1);
            gntId   <= '0;
            cnt     <= '0;
            opA     <= '0;
            opB     <= '0;
            res     <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (accepting && anyReq) begin
                        opA   <= req_a[gntIdx];
                        opB   <= req_b[gntIdx];
                        gntId <= gntIdx;
                        cnt   <= CntW'(LATENCY - 1);
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        res   <= fp_result;
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        lastGnt <= gntId;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
